// File: rtl/axis_cond_pkg.sv
// ============================================================================
// Module   : axis_cond_pkg
// Brief    : Shared types and constants for the condition-extract front stage
// Revision : 1.0
// ============================================================================
`default_nettype none

package axis_cond_pkg;

    localparam int DSIZE_DEF = 32;
    localparam int H_DEF     = 7;
    localparam int L_DEF     = 0;
    localparam int CW        = H_DEF - L_DEF + 1;

    // Buffer entry for the default configuration; the top re-declares the
    // same layout against its own parameters.
    typedef struct packed {
        logic [DSIZE_DEF-1:0] data;
        logic                 last;
        logic [CW-1:0]        cond;
        logic                 sop;
    } cond_entry_t;

    function automatic int entry_width(input int dsize, input int cw);
        return dsize + cw + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_stream_inf.sv
// ============================================================================
// Module   : axi_stream_inf
// Brief    : Minimal AXI-stream bundle (tvalid/tready/tdata/tlast)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axi_stream_inf #(
    parameter int DSIZE = 32
) ();
    logic             aclk;
    logic             aresetn;
    logic             axis_tvalid;
    logic             axis_tready;
    logic             axis_tlast;
    logic [DSIZE-1:0] axis_tdata;

    modport master (
        input  aclk, aresetn, axis_tready,
        output axis_tvalid, axis_tdata, axis_tlast
    );

    modport slaver (
        input  aclk, aresetn, axis_tvalid, axis_tdata, axis_tlast,
        output axis_tready
    );
endinterface

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// ============================================================================
// Module   : axis_skid_buffer
// Brief    : Generic 2-entry valid/ready buffer, main + skid register
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_accept;
    logic             w_consume;

    // Ready comes from the skid flag only; rst masks it so nothing enters
    // during any reset cycle, including the first one.
    assign in_ready  = ~r_skid_valid & ~rst;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_valid & out_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (w_consume || !r_main_valid) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_data <= in_data;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_condition_extract.sv
// ============================================================================
// Module   : axis_condition_extract
// Brief    : Tags every beat with its packet's header field [H:L] and counts
//            completed packets, behind a registered skid buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_condition_extract
    import axis_cond_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int H     = H_DEF,
    parameter int L     = L_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst,
    axi_stream_inf.slaver    axis_in,
    axi_stream_inf.master    axis_out,
    output logic [H-L:0]     condition_data,
    output logic             out_sop,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int COND_W = H - L + 1;
    localparam int EW     = entry_width(DSIZE, COND_W);

    typedef struct packed {
        logic [DSIZE-1:0]  data;
        logic              last;
        logic [COND_W-1:0] cond;
        logic              sop;
    } entry_t;

    logic              r_in_first;
    logic [COND_W-1:0] r_held_cond;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_out_valid;
    logic              w_consume;
    logic [COND_W-1:0] w_field;
    logic [EW-1:0]     w_out_bits;
    entry_t            w_in_entry;
    entry_t            w_out_entry;
    logic              w_unused_aux;

    assign w_unused_aux = ^{axis_in.aclk, axis_in.aresetn, axis_out.aclk, axis_out.aresetn};

    assign w_field  = axis_in.axis_tdata[H:L];
    assign w_accept = axis_in.axis_tvalid & w_in_ready;

    // The condition is resolved before buffering so it travels with its beat.
    always_comb begin
        w_in_entry      = '0;
        w_in_entry.data = axis_in.axis_tdata;
        w_in_entry.last = axis_in.axis_tlast;
        w_in_entry.cond = r_in_first ? w_field : r_held_cond;
        w_in_entry.sop  = r_in_first;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_in_first  <= 1'b1;
            r_held_cond <= '0;
        end else if (w_accept) begin
            r_in_first <= axis_in.axis_tlast;
            if (r_in_first) begin
                r_held_cond <= w_field;
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH (EW)
    ) u_skid (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (axis_in.axis_tvalid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_entry),
        .out_valid (w_out_valid),
        .out_ready (axis_out.axis_tready),
        .out_data  (w_out_bits)
    );

    assign w_out_entry = w_out_bits;
    assign w_consume   = w_out_valid & axis_out.axis_tready;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (w_consume && w_out_entry.last) begin
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
    end

    assign axis_in.axis_tready  = w_in_ready;
    assign axis_out.axis_tvalid = w_out_valid;
    assign axis_out.axis_tdata  = w_out_entry.data;
    assign axis_out.axis_tlast  = w_out_entry.last;
    assign condition_data       = w_out_entry.cond;
    assign out_sop              = w_out_valid & w_out_entry.sop;
    assign pkt_cnt              = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axis_condition_extract.sv
// ============================================================================
// Module   : tb_axis_condition_extract
// Brief    : Directed bench for axis_condition_extract (H=7, L=0)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axis_condition_extract;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_stream_inf #(.DSIZE(32)) in_if ();
    axi_stream_inf #(.DSIZE(32)) out_if ();
    axi_stream_inf #(.DSIZE(32)) in2_if ();
    axi_stream_inf #(.DSIZE(32)) out2_if ();

    assign in_if.aclk         = clk;
    assign in_if.aresetn      = ~rst;
    assign in_if.axis_tvalid  = in_valid;
    assign in_if.axis_tdata   = in_data;
    assign in_if.axis_tlast   = in_last;
    assign out_if.aclk        = clk;
    assign out_if.aresetn     = ~rst;
    assign out_if.axis_tready = out_ready;

    assign in2_if.aclk         = clk;
    assign in2_if.aresetn      = ~rst;
    assign in2_if.axis_tvalid  = in_valid;
    assign in2_if.axis_tdata   = in_data;
    assign in2_if.axis_tlast   = in_last;
    assign out2_if.aclk        = clk;
    assign out2_if.aresetn     = ~rst;
    assign out2_if.axis_tready = out_ready;

    logic [7:0]  cond;
    logic        sop;
    logic [15:0] cnt;
    logic [7:0]  cond2;
    logic        sop2;
    logic [3:0]  cnt2;

    axis_condition_extract #(.DSIZE(32), .H(7), .L(0), .CNT_W(16)) dut (
        .clock          (clk),
        .rst            (rst),
        .axis_in        (in_if),
        .axis_out       (out_if),
        .condition_data (cond),
        .out_sop        (sop),
        .pkt_cnt        (cnt)
    );

    axis_condition_extract #(.DSIZE(32), .H(7), .L(0), .CNT_W(4)) dut_w4 (
        .clock          (clk),
        .rst            (rst),
        .axis_in        (in2_if),
        .axis_out       (out2_if),
        .condition_data (cond2),
        .out_sop        (sop2),
        .pkt_cnt        (cnt2)
    );

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    assign in_ready  = in_if.axis_tready;
    assign out_valid = out_if.axis_tvalid;
    assign out_data  = out_if.axis_tdata;
    assign out_last  = out_if.axis_tlast;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(32'hDEADBEEF, 1'b1);
        cyc();
        cyc();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
        n_tests++; if (cond !== 8'h00) begin n_fail++; $display("FAIL reset_cond got=%0h exp=0", cond); end
        n_tests++; if (sop !== 1'b0) begin n_fail++; $display("FAIL reset_sop got=%0h exp=0", sop); end
        n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0h exp=0", cnt); end
        n_tests++; if (cnt2 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt_w4 got=%0h exp=0", cnt2); end
        rst = 1'b0;
        idle();
        cyc();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%0h exp=1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got=%0h exp=0", out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] d [4];
        d = '{32'h000000A5, 32'hFFFFFF3C, 32'h12345600, 32'h000000FF};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(d[k], k == 3);
            cyc();
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%0h exp=1", k, out_valid); end
            n_tests++; if (out_data !== d[k]) begin n_fail++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", k, out_data, d[k]); end
            n_tests++; if (cond !== 8'hA5) begin n_fail++; $display("FAIL stream_cond[%0d] got=%0h exp=a5", k, cond); end
            n_tests++; if (sop !== (k == 0)) begin n_fail++; $display("FAIL stream_sop[%0d] got=%0h exp=%0h", k, sop, (k == 0)); end
        end
        idle();
        cyc();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained got=%0h exp=0", out_valid); end
        n_tests++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL stream_cnt got=%0h exp=1", cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [3];
        logic [7:0]  e [3];
        d = '{32'hABCDEF11, 32'h00000022, 32'h55555533};
        e = '{8'h11, 8'h22, 8'h33};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(d[k], 1'b1);
            cyc();
            n_tests++; if (out_data !== d[k]) begin n_fail++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", k, out_data, d[k]); end
            n_tests++; if (cond !== e[k]) begin n_fail++; $display("FAIL b2b_cond[%0d] got=%0h exp=%0h", k, cond, e[k]); end
            n_tests++; if (sop !== 1'b1) begin n_fail++; $display("FAIL b2b_sop[%0d] got=%0h exp=1", k, sop); end
        end
        idle();
        cyc();
        n_tests++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_cnt got=%0h exp=3", cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        drive(32'h0000005A, 1'b0);
        cyc();
        drive(32'h11111101, 1'b0);
        cyc();
        drive(32'h22222202, 1'b0);
        out_ready = 1'b0;
        cyc();
        drive(32'h33333303, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, in_ready); end
            n_tests++; if (out_data !== 32'h11111101) begin n_fail++; $display("FAIL bp_hold_data[%0d] got=%0h exp=11111101", i, out_data); end
            n_tests++; if (cond !== 8'h5A || sop !== 1'b0) begin n_fail++; $display("FAIL bp_hold_cond[%0d] got=%0h/%0h exp=5a/0", i, cond, sop); end
            if (i < 4) cyc();
        end
        out_ready = 1'b1;
        cyc();
        n_tests++; if (out_data !== 32'h22222202) begin n_fail++; $display("FAIL bp_skid_data got=%0h exp=22222202", out_data); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%0h exp=1", in_ready); end
        cyc();
        n_tests++; if (out_data !== 32'h33333303) begin n_fail++; $display("FAIL bp_next_data got=%0h exp=33333303", out_data); end
        drive(32'h44444404, 1'b0);
        cyc();
        n_tests++; if (out_data !== 32'h44444404) begin n_fail++; $display("FAIL bp_d4 got=%0h exp=44444404", out_data); end
        drive(32'h55555505, 1'b1);
        cyc();
        n_tests++; if (out_data !== 32'h55555505 || out_last !== 1'b1 || cond !== 8'h5A) begin n_fail++; $display("FAIL bp_last got=%0h/%0h/%0h exp=55555505/1/5a", out_data, out_last, cond); end
        idle();
        cyc();
        n_tests++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL bp_cnt got=%0h exp=1", cnt); end
    endtask

    task automatic test_cond_isolation();
        do_reset();
        out_ready = 1'b1;
        drive(32'h00000001, 1'b0);
        cyc();
        drive(32'h000000EE, 1'b1);
        cyc();
        out_ready = 1'b0;
        drive(32'hFFFFFF02, 1'b0);
        cyc();
        n_tests++; if (out_data !== 32'h000000EE || cond !== 8'h01 || out_last !== 1'b1) begin n_fail++; $display("FAIL iso_a_last got=%0h/%0h/%0h exp=ee/01/1", out_data, cond, out_last); end
        drive(32'h00000099, 1'b1);
        cyc();
        n_tests++; if (cond !== 8'h01) begin n_fail++; $display("FAIL iso_a_hold got=%0h exp=01", cond); end
        out_ready = 1'b1;
        cyc();
        n_tests++; if (out_data !== 32'hFFFFFF02 || cond !== 8'h02 || sop !== 1'b1) begin n_fail++; $display("FAIL iso_b_first got=%0h/%0h/%0h exp=ffffff02/02/1", out_data, cond, sop); end
        cyc();
        n_tests++; if (out_data !== 32'h00000099 || cond !== 8'h02 || sop !== 1'b0) begin n_fail++; $display("FAIL iso_b_last got=%0h/%0h/%0h exp=99/02/0", out_data, cond, sop); end
        idle();
        cyc();
        n_tests++; if (cnt !== 16'd2) begin n_fail++; $display("FAIL iso_cnt got=%0h exp=2", cnt); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(32'h00000033, 1'b0);
        cyc();
        drive(32'h00000044, 1'b0);
        cyc();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty got=%0h/%0h exp=0/1", out_valid, in_ready); end
        n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt got=%0h exp=0", cnt); end
        out_ready = 1'b1;
        drive(32'h1234567F, 1'b0);
        cyc();
        n_tests++; if (cond !== 8'h7F || sop !== 1'b1) begin n_fail++; $display("FAIL mid_rst_first got=%0h/%0h exp=7f/1", cond, sop); end
        drive(32'h00000080, 1'b1);
        cyc();
        n_tests++; if (cond !== 8'h7F || sop !== 1'b0) begin n_fail++; $display("FAIL mid_rst_second got=%0h/%0h exp=7f/0", cond, sop); end
        idle();
        cyc();
        n_tests++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL mid_rst_cnt_after got=%0h exp=1", cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(32'h00000100 + i, 1'b1);
            cyc();
        end
        idle();
        cyc();
        n_tests++; if (cnt2 !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt_w4 got=%0h exp=1", cnt2); end
        n_tests++; if (cnt !== 16'd17) begin n_fail++; $display("FAIL wrap_cnt_w16 got=%0h exp=11", cnt); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_backpressure();
        test_cond_isolation();
        test_reset_mid_packet();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_condition_extract.md
# axis_condition_extract

Packet-aware front stage for the AXI-stream mirror/splitter. For each packet it captures a header field, bits [H:L] of the first beat, and presents it on `condition_data`. The value is held stable and beat-aligned for the whole packet, so the downstream mirror can route every beat of a packet by one decision. Data passes through a registered 2-entry skid buffer: full throughput, registered `tready`, one cycle of latency.

## Interface
- `DSIZE`, 32: axis_tdata width; must equal `axis_in.DSIZE`.
- `H`, 7: MSB of the condition field in the first beat; `L <= H < DSIZE`.
- `L`, 0: LSB of the condition field.
- `CNT_W`, 16: width of the completed-packet counter.

Ports (clock and reset first):
- `clock`, input, 1: sole clock. The `aclk` fields of both interfaces are ignored.
- `rst`, input, 1: synchronous, active-high reset. The `aresetn` fields of both interfaces are ignored.
- `axis_in`, `axi_stream_inf.slaver`, DSIZE: upstream stream (tvalid/tready/tdata/tlast).
- `axis_out`, `axi_stream_inf.master`, DSIZE: the same beats, delayed.
- `condition_data`, output, H-L+1: field of the current output packet; meaningful while `axis_out.axis_tvalid` is high.
- `out_sop`, output, 1: high when the current output beat is the first beat of its packet.
- `pkt_cnt`, output, CNT_W: count of packets whose tlast beat was accepted at `axis_out`; wraps modulo 2^CNT_W.

## Operation
- Input first-beat flag `in_first`:
  - set by reset;
  - set by an accepted beat with tlast=1;
  - cleared by an accepted beat with tlast=0.
- Per-beat condition, computed at the input:
  - if `in_first`: `tdata[H:L]` of this beat;
  - otherwise: `held_cond`.
  - `held_cond` loads `tdata[H:L]` on every accepted beat where `in_first`=1.
- Each buffer entry stores {tdata, tlast, cond, sop}, so a condition always travels with its own beats. A new packet's first beat never alters the condition of a still-buffered previous packet.
- Skid buffer: a main output register plus one skid register.
  - Input accepted when `tvalid && tready`.
  - Output consumed when `axis_out.axis_tvalid && axis_out.axis_tready`.
  - Data order is strictly preserved; no beat is dropped or duplicated.
- `pkt_cnt` increments by 1 on each consumed output beat with tlast=1.
- Single-beat packet (tlast on the first beat): condition is taken from that beat, `out_sop`=1, and the next beat is again a first beat.
- Bits of tdata outside [H:L] never affect the condition.

## Timing
- Reset values, for every cycle with `rst`=1:
  - `axis_out.axis_tvalid`=0, `axis_in.axis_tready`=0
  - `condition_data`=0, `out_sop`=0, `pkt_cnt`=0
  - buffer empty, `in_first`=1, `held_cond`=0
- Reset mid-packet: all buffered beats are discarded and the partial packet is not counted. The first beat accepted after reset is treated as a first beat.
- `axis_in.axis_tready` is a register output: high exactly when the skid register is empty. It is never combinationally dependent on `axis_out.axis_tready`.
- Latency: a beat accepted in cycle N appears on `axis_out` in cycle N+1 if the main register is free or is being drained in cycle N.
- Throughput: 1 beat/cycle sustained while downstream ready stays high.
- Backpressure: when downstream ready drops, at most one further input beat is absorbed into the skid register, then `tready` falls the next cycle.
- Drain order when ready returns: main register first, then the skid register, then new input.
- While `axis_out.axis_tvalid`=1 and `axis_out.axis_tready`=0, the outputs `tdata`, `tlast`, `condition_data` and `out_sop` are held constant (AXI-stream stability).
- Accept and consume in the same cycle are legal in every buffer state. Occupancy changes by (accept − consume).

## Structure
- Shared package `axis_cond_pkg`:
  - entry struct typedef {data, last, cond, sop}, parameterised through `DSIZE`, `H`, `L`;
  - localparam `CW = H-L+1`.
- Natural sub-module: `axis_skid_buffer`, a generic 2-entry registered-ready buffer of width `DSIZE+1+CW+1`. This module instantiates it and adds the first-beat tracking and the counter (~200 lines total).

## Test plan
- Continuous stream, ready=1, DSIZE=32, H=7, L=0, 4-beat packet with first tdata=0x000000A5 → `condition_data`=0xA5 for all 4 output beats; `out_sop`=1 on beat 0 only; `pkt_cnt`=1; 1-cycle latency.
- Back-to-back single-beat packets with field 0x11, 0x22, 0x33 → conditions 0x11, 0x22, 0x33, each with `out_sop`=1; `pkt_cnt`=3.
- Output ready low for 5 cycles mid-packet with input valid held high → exactly one extra beat absorbed; `axis_in.axis_tready` low from the next cycle; outputs stable; no loss or reorder after release.
- Packet A (field 0x01) tlast is stalled in the buffer while packet B's first beat (field 0x02) is accepted → A's last beat still shows 0x01, B shows 0x02.
- `rst` pulsed after 2 of 4 beats; then a fresh 2-beat packet with field 0x7F → buffer empty and `pkt_cnt`=0 after reset; new packet shows 0x7F and `out_sop`=1; `pkt_cnt`=1.
- `CNT_W`=4, 17 packets → `pkt_cnt` wraps to 1.
